// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed in
//   DIGIT-bit slices, one slice per clock, least significant slice first.
//   The carry between slices is held in a register. Subtraction is done as
//   a + ~b + ~cin, so cout is NOT borrow-out when sub = 1.
//
//   Parameters
//     WIDTH : operand / result width (>= 1)
//     DIGIT : bits processed per clock (>= 1, must divide WIDTH)
//
//   Ports
//     clk      : clock, rising edge
//     rst      : asynchronous active-high reset
//     start    : request, sampled in IDLE or DONE
//     a, b     : operands, captured on the accepting edge
//     cin      : carry-in (add) / borrow-in (sub), captured on accept
//     sub      : 0 = add, 1 = subtract, captured on accept
//     busy     : high while slices are processed
//     done     : one-cycle pulse, results valid
//     sum      : result register
//     cout     : carry-out (add) / NOT borrow-out (sub)
//     overflow : two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;        // already inverted for subtraction
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, done_q;

  logic [31:0]      base_s;
  logic [DIGIT-1:0] a_sl_s;
  logic [DIGIT-1:0] b_sl_s;
  logic [DIGIT:0]   slice_s;
  logic             msb_cin_s;

  // Current slice operands, slice sum and the carry into the slice's top bit.
  always_comb begin
    base_s    = 32'(k_q) * 32'(DIGIT);
    a_sl_s    = a_q[base_s +: DIGIT];
    b_sl_s    = b_q[base_s +: DIGIT];
    slice_s   = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{DIGIT{1'b0}}, carry_q};
    // Carry into the top bit recovered from its sum bit; for DIGIT = 1 this
    // is carry_q itself, which covers the WIDTH = 1 case as well.
    msb_cin_s = slice_s[DIGIT-1] ^ a_sl_s[DIGIT-1] ^ b_sl_s[DIGIT-1];
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          k_d     = {KW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[base_s +: DIGIT] = slice_s[DIGIT-1:0];
        carry_d                = slice_s[DIGIT];
        if (k_q == K_LAST) begin
          cout_d  = slice_s[DIGIT];
          ovf_d   = msb_cin_s ^ slice_s[DIGIT];
          k_d     = {KW{1'b0}};
          state_d = S_DONE;
        end else begin
          k_d     = k_q + K_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand, result and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      k_q     <= {KW{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: four instances (WIDTH=8, DIGIT=1/2/4/8) share
// stimulus; results are compared with an arithmetic reference model.
module tb_serial_adder;

  logic            clk;
  logic            rst;
  logic            start;
  logic [7:0]      a;
  logic [7:0]      b;
  logic            cin;
  logic            sub;
  logic [3:0]      busy_s;
  logic [3:0]      done_s;
  logic [3:0][7:0] sum_s;
  logic [3:0]      cout_s;
  logic [3:0]      ovf_s;

  int n_chk;
  int n_pass;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .sum      (sum_s[g]),
      .cout     (cout_s[g]),
      .overflow (ovf_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [9:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic rci, input logic rsub);
    int ua, ub, sa, sb, r, sr;
    logic c, v;
    logic [7:0] s;
    ua = int'(ra);
    ub = int'(rb);
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (!rsub) begin
      r  = ua + ub + int'(rci);
      sr = sa + sb + int'(rci);
      c  = (r > 255);
    end else begin
      r  = ua - ub - int'(rci);
      sr = sa - sb - int'(rci);
      c  = (r >= 0);
    end
    s = 8'(r & 255);
    v = (sr > 127) || (sr < -128);
    return {v, c, s};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input int g, input logic [9:0] e, input string what);
    chk($sformatf("%s_sum dut%0d", what, g), 32'(sum_s[g]), 32'(e[7:0]));
    chk($sformatf("%s_cout dut%0d", what, g), 32'(cout_s[g]), 32'(e[8]));
    chk($sformatf("%s_ovf dut%0d", what, g), 32'(ovf_s[g]), 32'(e[9]));
  endtask

  // One operation; optionally a conflicting start pulse while running.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                        input logic tsb, input bit glitch);
    logic [9:0] e;
    e = ref_op(ta, tb, tci, tsb);
    a = ta; b = tb; cin = tci; sub = tsb; start = 1'b1;
    step();
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) step();
      for (int g = 0; g < 4; g++) begin
        int n;
        n = 8 >> g;
        chk($sformatf("busy dut%0d j%0d", g, j), 32'(busy_s[g]), 32'(j < n));
        chk($sformatf("done dut%0d j%0d", g, j), 32'(done_s[g]), 32'(j == n));
        if (j >= n) chk_result(g, e, "op");
      end
      if (j == 0) begin
        if (glitch) begin
          a = ~ta; b = ta ^ tb ^ 8'h5A; cin = ~tci; sub = ~tsb;
        end else begin
          start = 1'b0;
        end
      end
      if (j == 1) start = 1'b0;
    end
  endtask

  // start held high: second operation accepted in the DONE cycle.
  task automatic run_chain(input logic [7:0] a1, input logic [7:0] b1, input logic c1,
                           input logic [7:0] a2, input logic [7:0] b2, input logic c2);
    logic [9:0] e1, e2;
    e1 = ref_op(a1, b1, c1, 1'b0);
    e2 = ref_op(a2, b2, c2, 1'b0);
    a = a1; b = b1; cin = c1; sub = 1'b0; start = 1'b1;
    step();
    for (int j = 0; j <= 17; j++) begin
      if (j > 0) step();
      for (int g = 0; g < 4; g++) begin
        int n;
        n = 8 >> g;
        if (j == n) begin
          chk($sformatf("chain_done1 dut%0d", g), 32'(done_s[g]), 32'd1);
          chk_result(g, e1, "chain1");
        end
        if (j == n + 1) chk($sformatf("chain_nobubble dut%0d", g), 32'(busy_s[g]), 32'd1);
        if (j == 2 * n + 1) begin
          chk($sformatf("chain_done2 dut%0d", g), 32'(done_s[g]), 32'd1);
          chk_result(g, e2, "chain2");
        end
      end
      if (j == 0) begin
        a = a2; b = b2; cin = c2;
      end
    end
    start = 1'b0;
    for (int j = 0; j < 10; j++) step();
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    step();
    step();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_busy dut%0d", g), 32'(busy_s[g]), 32'd0);
      chk($sformatf("rst_done dut%0d", g), 32'(done_s[g]), 32'd0);
      chk_result(g, 10'd0, "rst");
    end
    #3 rst = 1'b0;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    run_chain(8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);

    // Reset in the second RUN cycle must clear outputs without a clock edge.
    a = 8'hC3; b = 8'h7E; cin = 1'b1; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("midrst_busy dut%0d", g), 32'(busy_s[g]), 32'd0);
      chk($sformatf("midrst_done dut%0d", g), 32'(done_s[g]), 32'd0);
      chk_result(g, 10'd0, "midrst");
    end
    #1 rst = 1'b0;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
